power_throttle_ctrl: RTL and testbench

POWER_THROTTLE_CTRL -- requirements
Module: power_throttle_ctrl

---
 rtl/pmu_pkg.sv | 16 +
 rtl/pmu_debounce_cnt.sv | 19 +
 rtl/power_throttle_ctrl.sv | 109 ++++++++++
 tb/tb_power_throttle_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// pmu_pkg: shared PMU throttle state encoding, irq cause and alarm flag bit indices
package pmu_pkg;
  typedef enum logic [1:0] {ST_NORMAL, ST_REQ, ST_HOLD, ST_SHUTDOWN} pmu_state_e;
  localparam int CAUSE_UP = 0;
  localparam int CAUSE_DN = 1;
  localparam int CAUSE_OV = 2;
  localparam int CAUSE_UV = 3;
  localparam int CAUSE_TW = 4;
  localparam int CAUSE_OC = 5;
  localparam int CAUSE_SD = 6;
  localparam int AF_OV = 0;
  localparam int AF_UV = 1;
  localparam int AF_TW = 2;
  localparam int AF_TC = 3;
  localparam int AF_OC = 4;
endpackage

// File: rtl/pmu_debounce_cnt.sv
// pmu_debounce_cnt: saturating count of consecutive qualifying samples
module pmu_debounce_cnt #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic inc,
  input  logic clr,
  output logic full
);
  localparam int W = $clog2(N + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : !inc ? '0 : full ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign full = cnt_q == W'(N);
endmodule

// File: rtl/power_throttle_ctrl.sv
// power_throttle_ctrl: debounced DVFS throttle stepping with handshake, hold-off,
// critical-temperature shutdown and sticky interrupt causes
module power_throttle_ctrl
  import pmu_pkg::*;
#(
  parameter int DEBOUNCE_N = 4,
  parameter int HOLD_CYC   = 256,
  parameter int CRIT_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [31:0] consumption,
  input  logic [31:0] budget,
  input  logic [15:0] alarm_flags,
  output logic [2:0]  throttle_level,
  output logic        throttle_req,
  input  logic        throttle_ack,
  output logic        shutdown_req,
  output logic        irq,
  output logic [7:0]  irq_cause,
  input  logic [7:0]  irq_clr
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int CW = $clog2(CRIT_CYC + 1);
  pmu_state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] crit_q, crit_d;
  logic [4:0] alarm_q;
  logic [2:0] level_q, level_d;
  logic [7:0] cause_q, cause_d;
  logic [6:0] cause_set;
  logic req_q, req_d, shut_q, shut_d, up_q, up_d;
  logic over, under, up_full, dn_full, crit_hit, go_up, go_dn;
  logic unused_bits;
  assign unused_bits = ^{alarm_flags[15:5], irq_clr[7]};
  assign over = consumption > budget || alarm_flags[AF_TW] || alarm_flags[AF_OC];
  assign under = budget != 32'd0 && consumption < budget - (budget >> 3) && alarm_flags[4:0] == 5'd0;
  assign crit_hit = alarm_flags[AF_TC] && crit_q == CW'(CRIT_CYC - 1);
  assign crit_d = !alarm_flags[AF_TC] ? '0 : crit_hit ? crit_q : crit_q + 1'b1;
  assign go_up = (state_q == ST_NORMAL || state_q == ST_HOLD) && up_full && level_q != 3'd7;
  assign go_dn = state_q == ST_NORMAL && dn_full && level_q != 3'd0 && !go_up;
  pmu_debounce_cnt #(.N(DEBOUNCE_N)) u_up_cnt (
    .clk(clk), .rst(rst), .en(sample_valid), .inc(over), .clr(go_up || go_dn), .full(up_full)
  );
  pmu_debounce_cnt #(.N(DEBOUNCE_N)) u_dn_cnt (
    .clk(clk), .rst(rst), .en(sample_valid), .inc(under), .clr(go_up || go_dn), .full(dn_full)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_NORMAL;
      hold_q  <= '0;
      crit_q  <= '0;
      up_q    <= 1'b0;
      alarm_q <= '0;
      level_q <= '0;
      req_q   <= 1'b0;
      shut_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      crit_q  <= crit_d;
      up_q    <= up_d;
      alarm_q <= alarm_flags[4:0];
      level_q <= level_d;
      req_q   <= req_d;
      shut_q  <= shut_d;
      cause_q <= cause_d;
    end
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    up_d    = up_q;
    if (state_q == ST_SHUTDOWN || crit_hit) state_d = ST_SHUTDOWN;
    else if (go_up || go_dn) begin
      state_d = ST_REQ;
      up_d    = go_up;
    end else if (state_q == ST_REQ && throttle_ack) begin
      state_d = ST_HOLD;
      hold_d  = HW'(HOLD_CYC);
    end else if (state_q == ST_HOLD) begin
      state_d = hold_q == '0 ? ST_NORMAL : ST_HOLD;
      hold_d  = hold_q == '0 ? hold_q : hold_q - 1'b1;
    end
  end
  // outputs are precomputed from the next state so they stay registered
  always_comb begin
    level_d = state_d == ST_SHUTDOWN ? 3'd7
            : (state_d == ST_REQ && state_q != ST_REQ) ? (go_up ? level_q + 3'd1 : level_q - 3'd1)
            : level_q;
    req_d   = state_d == ST_REQ;
    shut_d  = state_d == ST_SHUTDOWN;
    cause_set = '0;
    cause_set[CAUSE_UP] = state_q == ST_REQ && state_d == ST_HOLD && up_q;
    cause_set[CAUSE_DN] = state_q == ST_REQ && state_d == ST_HOLD && !up_q;
    cause_set[CAUSE_OV] = alarm_flags[AF_OV] && !alarm_q[AF_OV];
    cause_set[CAUSE_UV] = alarm_flags[AF_UV] && !alarm_q[AF_UV];
    cause_set[CAUSE_TW] = alarm_flags[AF_TW] && !alarm_q[AF_TW];
    cause_set[CAUSE_OC] = alarm_flags[AF_OC] && !alarm_q[AF_OC];
    cause_set[CAUSE_SD] = state_d == ST_SHUTDOWN && state_q != ST_SHUTDOWN;
    cause_d = {1'b0, (cause_q[6:0] & ~irq_clr[6:0]) | cause_set};
  end
  assign throttle_level = level_q;
  assign throttle_req   = req_q;
  assign shutdown_req   = shut_q;
  assign irq_cause      = cause_q;
  assign irq            = |cause_q;
endmodule

// File: tb/tb_power_throttle_ctrl.sv
// tb_power_throttle_ctrl: directed scenarios plus random stimulus checked against a behavioural model
module tb_power_throttle_ctrl;
  localparam int DN = 4;
  localparam int HC = 256;
  localparam int CC = 4;
  localparam int M_NORM = 0, M_REQ = 1, M_HOLD = 2, M_SD = 3;
  logic clk = 1'b0;
  logic rst, sample_valid, throttle_ack, throttle_req, shutdown_req, irq;
  logic [31:0] consumption, budget;
  logic [15:0] alarm_flags;
  logic [2:0] throttle_level;
  logic [7:0] irq_cause, irq_clr;
  int n_vec = 0;
  int n_bad = 0;
  int m_mode, m_level, m_up, m_dn, m_hold, m_crit, m_dir;
  logic [7:0] m_cause;
  logic [4:0] m_prev;
  always #5 clk = ~clk;
  power_throttle_ctrl #(.DEBOUNCE_N(DN), .HOLD_CYC(HC), .CRIT_CYC(CC)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .consumption(consumption),
    .budget(budget), .alarm_flags(alarm_flags), .throttle_level(throttle_level),
    .throttle_req(throttle_req), .throttle_ack(throttle_ack), .shutdown_req(shutdown_req),
    .irq(irq), .irq_cause(irq_cause), .irq_clr(irq_clr)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = M_NORM; m_level = 0; m_up = 0; m_dn = 0; m_hold = 0; m_crit = 0; m_dir = 0;
    m_cause = '0; m_prev = '0;
  endtask
  task automatic model_step();
    bit over, under, stepped;
    logic [7:0] set;
    logic [4:0] rise;
    int crit_n;
    over = consumption > budget || alarm_flags[2] || alarm_flags[4];
    under = budget != 0 && consumption < budget - budget / 8 && alarm_flags[4:0] == 0;
    set = '0;
    stepped = 0;
    crit_n = alarm_flags[3] ? m_crit + 1 : 0;
    if (m_mode == M_SD) begin
    end else if (crit_n >= CC) begin
      m_mode = M_SD; m_level = 7; set[6] = 1'b1;
    end else if ((m_mode == M_NORM || m_mode == M_HOLD) && m_up == DN && m_level < 7) begin
      m_level++; m_dir = 1; m_mode = M_REQ; stepped = 1;
    end else if (m_mode == M_NORM && m_dn == DN && m_level > 0) begin
      m_level--; m_dir = 0; m_mode = M_REQ; stepped = 1;
    end else if (m_mode == M_REQ && throttle_ack) begin
      m_mode = M_HOLD; m_hold = HC; set[m_dir ? 0 : 1] = 1'b1;
    end else if (m_mode == M_HOLD) begin
      if (m_hold == 0) m_mode = M_NORM;
      else m_hold--;
    end
    m_crit = crit_n > CC ? CC : crit_n;
    if (stepped) begin
      m_up = 0; m_dn = 0;
    end else if (sample_valid) begin
      m_up = over ? (m_up < DN ? m_up + 1 : DN) : 0;
      m_dn = under ? (m_dn < DN ? m_dn + 1 : DN) : 0;
    end
    rise = alarm_flags[4:0] & ~m_prev;
    set[5:2] = {rise[4], rise[2], rise[1], rise[0]};
    m_cause = (m_cause & ~irq_clr) | set;
    m_cause[7] = 1'b0;
    m_prev = alarm_flags[4:0];
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("level", throttle_level, m_level);
    check("req", throttle_req, m_mode == M_REQ);
    check("shutdown", shutdown_req, m_mode == M_SD);
    check("cause", irq_cause, m_cause);
    check("irq", irq, |m_cause);
  endtask
  task automatic strobe(input logic [31:0] c);
    sample_valid = 1'b1; consumption = c;
    tick();
    sample_valid = 1'b0;
  endtask
  task automatic ack_once();
    throttle_ack = 1'b1;
    tick();
    throttle_ack = 1'b0;
  endtask
  task automatic clr_all();
    irq_clr = 8'hff;
    tick();
    irq_clr = '0;
  endtask
  task automatic wait_req();
    for (int i = 0; i < 10 && m_mode != M_REQ; i++) tick();
    check("req_timeout", throttle_req, 1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_level", throttle_level, 0);
    check("rst_req", throttle_req, 0);
    check("rst_irq", irq, 0);
    check("rst_shutdown", shutdown_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    sample_valid = 0; consumption = 0; budget = 10000; alarm_flags = 0;
    throttle_ack = 0; irq_clr = 0;
    model_reset();
    do_reset();
    check("rst_cause", irq_cause, 0);
    // single step up and its acknowledge
    repeat (DN) strobe(12000);
    wait_req();
    check("up_level", throttle_level, 1);
    ack_once();
    check("up_req_drop", throttle_req, 0);
    check("up_cause0", irq_cause[0], 1);
    check("up_irq", irq, 1);
    clr_all();
    // step down is blocked by the hold timer, then allowed
    repeat (DN) strobe(8000);
    tick();
    check("hold_blocks_dn", throttle_req, 0);
    for (int i = 0; i < HC + 20 && m_mode != M_NORM; i++) tick();
    repeat (DN) strobe(8000);
    wait_req();
    check("dn_level", throttle_level, 0);
    ack_once();
    check("dn_cause1", irq_cause[1], 1);
    clr_all();
    // set beats clear on the same cause bit
    alarm_flags = 16'h0001; irq_clr = 8'h04;
    tick();
    irq_clr = '0;
    check("set_prio", irq_cause[2], 1);
    tick();
    irq_clr = 8'h04;
    tick();
    irq_clr = '0;
    alarm_flags = 0;
    check("clr_cause2", irq_cause[2], 0);
    check("clr_irq", irq, 0);
    // climb to level 7, then over no longer requests
    for (int s = 0; s < 7; s++) begin
      repeat (DN) strobe(15000);
      wait_req();
      ack_once();
    end
    check("top_level", throttle_level, 7);
    for (int i = 0; i < 8; i++) begin
      strobe(15000);
      check("top_no_req", throttle_req, 0);
    end
    clr_all();
    // reset while a request is pending drops it asynchronously
    for (int i = 0; i < HC + 20 && m_mode != M_NORM; i++) tick();
    repeat (DN) strobe(5000);
    wait_req();
    check("pend_level", throttle_level, 6);
    do_reset();
    throttle_ack = 1'b1;
    tick();
    throttle_ack = 1'b0;
    check("late_ack", throttle_req, 0);
    check("late_ack_level", throttle_level, 0);
    // critical temperature debounce and sticky shutdown
    alarm_flags = 16'h0008;
    repeat (CC - 1) tick();
    alarm_flags = 0;
    tick();
    check("crit_short", shutdown_req, 0);
    alarm_flags = 16'h0008;
    repeat (CC) tick();
    check("crit_sd", shutdown_req, 1);
    check("crit_level", throttle_level, 7);
    check("crit_cause6", irq_cause[6], 1);
    alarm_flags = 0;
    repeat (5) tick();
    check("sd_sticky", shutdown_req, 1);
    do_reset();
    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if (i % 500 == 499) do_reset();
      budget = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 20000));
      consumption = budget == 0 ? 32'($urandom_range(0, 100))
                  : budget - budget / 4 + 32'($urandom_range(0, budget / 2));
      sample_valid = $urandom_range(0, 1) == 1;
      throttle_ack = $urandom_range(0, 2) == 0;
      irq_clr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      alarm_flags = 16'($urandom) & 16'hffe0;
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 29) == 0) alarm_flags[b] = 1'b1;
      if (m_prev[3] && $urandom_range(0, 3) != 0) alarm_flags[3] = 1'b1;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
